// File: rtl/if_stage_if.sv
// IF-to-ID handshake bundle: IF presents valid/pc/inst/exc, ID answers with id_allow_in.
interface if_stage_if;
  logic        if_to_id_valid;
  logic [31:0] if_to_id_pc;
  logic [31:0] if_to_id_inst;
  logic        if_to_id_exc;
  logic        id_allow_in;

  modport master (
    output if_to_id_valid,
    output if_to_id_pc,
    output if_to_id_inst,
    output if_to_id_exc,
    input  id_allow_in
  );

  modport slave (
    input  if_to_id_valid,
    input  if_to_id_pc,
    input  if_to_id_inst,
    input  if_to_id_exc,
    output id_allow_in
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives a synchronous imem, presents fetched words to ID with a one-entry stall hold buffer.
// Optional macro IF_MISALIGN_EXC_EN turns on the fetch-address-misaligned flag.
module if_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        pre_if_valid,
  input  logic [31:0] pc,
  output logic        if_allow_in,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  if_stage_if.master  id_bus
);

  logic        if_valid;
  logic        hold_vld;
  logic [31:0] hold_inst;
  logic        misalign;
  logic        out_valid;

  assign if_allow_in = !if_valid || id_bus.id_allow_in || flush;
  assign imem_en     = if_allow_in && pre_if_valid;
  assign imem_addr   = next_pc;
  assign out_valid   = if_valid && !flush;

`ifdef IF_MISALIGN_EXC_EN
  assign misalign = (pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
    end else if (if_allow_in) begin
      if_valid <= pre_if_valid;
    end
  end

  // imem_rdata is only good for one cycle after the read, so a stalled word is parked here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld  <= 1'b0;
      hold_inst <= NOP_INST;
    end else if (if_allow_in) begin
      hold_vld  <= 1'b0;
    end else if (if_valid && !id_bus.id_allow_in && !flush && !hold_vld) begin
      hold_vld  <= 1'b1;
      hold_inst <= imem_rdata;
    end
  end

  assign id_bus.if_to_id_valid = out_valid;
  assign id_bus.if_to_id_pc    = pc;
  assign id_bus.if_to_id_exc   = out_valid && misalign;

  always_comb begin
    id_bus.if_to_id_inst = NOP_INST;
    if (out_valid && !misalign) begin
      id_bus.if_to_id_inst = hold_vld ? hold_inst : imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: stimulus pushes expected ID transfers, a negedge monitor pops and compares.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        pre_if_valid;
  logic [31:0] pc_r;
  logic        if_allow_in;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] rdata_r;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        ovr;

  if_stage_if id_bus ();

  if_stage #(.NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .next_pc      (next_pc),
    .pre_if_valid (pre_if_valid),
    .pc           (pc_r),
    .if_allow_in  (if_allow_in),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .flush        (flush),
    .id_bus       (id_bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hABCD_0093;
    return {16'hC0DE, a[15:0]};
  endfunction

  // Environment: PC register and a synchronous instruction memory.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_r <= 32'h0;
    else if (if_allow_in) pc_r <= next_pc;
  end

  always @(posedge clk) begin
    if (imem_en) rdata_r <= mem_word(imem_addr);
  end

  assign imem_rdata = ovr ? 32'hFFFF_FFFF : rdata_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] npc, input logic ida, input logic fl);
    @(posedge clk);
    #1;
    pre_if_valid       = pv;
    next_pc            = npc;
    id_bus.id_allow_in = ida;
    flush              = fl;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i, input logic e);
    exp_t x;
    x.pc = p; x.inst = i; x.exc = e;
    exp_q.push_back(x);
  endtask

  // Monitor: every accepted transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t x;
    if (id_bus.if_to_id_valid && id_bus.id_allow_in) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_transfer pc=%08h inst=%08h required=none", id_bus.if_to_id_pc, id_bus.if_to_id_inst);
      end else begin
        x = exp_q.pop_front();
        chk("xfer_pc", id_bus.if_to_id_pc, x.pc);
        chk("xfer_inst", id_bus.if_to_id_inst, x.inst);
        chk("xfer_exc", {31'b0, id_bus.if_to_id_exc}, {31'b0, x.exc});
      end
    end else if (!id_bus.if_to_id_valid) begin
      chk("idle_inst_nop", id_bus.if_to_id_inst, NOP);
    end
  end

  initial begin
    rst_n = 1'b0;
    pre_if_valid = 1'b0;
    next_pc = 32'h0;
    id_bus.id_allow_in = 1'b0;
    flush = 1'b0;
    ovr = 1'b0;
    #2;
    chk("rst_allow_in", {31'b0, if_allow_in}, 32'd1);
    chk("rst_valid", {31'b0, id_bus.if_to_id_valid}, 32'd0);
    chk("rst_inst", id_bus.if_to_id_inst, NOP);
    chk("rst_exc", {31'b0, id_bus.if_to_id_exc}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Back-to-back fetch of 0x0, 0x4, 0x8.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
      push(32'(i * 4), mem_word(32'(i * 4)), 1'b0);
      #1;
      chk("stream_imem_en", {31'b0, imem_en}, 32'd1);
      chk("stream_imem_addr", imem_addr, 32'(i * 4));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Three-cycle stall on 0x10 with memory data disturbed after capture.
    drive(1'b1, 32'h10, 1'b1, 1'b0);
    push(32'h10, 32'hABCD_0093, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h14, 1'b0, 1'b0);
      if (i == 1) ovr = 1'b1;
      #1;
      chk("stall_valid", {31'b0, id_bus.if_to_id_valid}, 32'd1);
      chk("stall_pc", id_bus.if_to_id_pc, 32'h10);
      chk("stall_inst", id_bus.if_to_id_inst, 32'hABCD_0093);
      chk("stall_imem_en", {31'b0, imem_en}, 32'd0);
    end
    drive(1'b1, 32'h14, 1'b1, 1'b0);
    ovr = 1'b0;
    push(32'h14, mem_word(32'h14), 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush during a stall, redirect to 0x200.
    drive(1'b1, 32'h20, 1'b1, 1'b0);
    drive(1'b1, 32'h24, 1'b0, 1'b0);
    drive(1'b1, 32'h200, 1'b0, 1'b1);
    push(32'h200, mem_word(32'h200), 1'b0);
    #1;
    chk("flush_valid", {31'b0, id_bus.if_to_id_valid}, 32'd0);
    chk("flush_allow_in", {31'b0, if_allow_in}, 32'd1);
    chk("flush_imem_en", {31'b0, imem_en}, 32'd1);
    chk("flush_imem_addr", imem_addr, 32'h200);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("redirect_valid", {31'b0, id_bus.if_to_id_valid}, 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with nothing behind it.
    drive(1'b1, 32'h30, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    chk("flush_nopv_valid", {31'b0, id_bus.if_to_id_valid}, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("after_flush_valid", {31'b0, id_bus.if_to_id_valid}, 32'd0);
    chk("after_flush_inst", id_bus.if_to_id_inst, NOP);

    // Misaligned fetch address.
    drive(1'b1, 32'h102, 1'b1, 1'b0);
`ifdef IF_MISALIGN_EXC_EN
    push(32'h102, NOP, 1'b1);
`else
    push(32'h102, mem_word(32'h102), 1'b0);
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
`ifdef IF_MISALIGN_EXC_EN
    chk("misalign_stall_exc", {31'b0, id_bus.if_to_id_exc}, 32'd1);
`else
    chk("misalign_stall_exc", {31'b0, id_bus.if_to_id_exc}, 32'd0);
`endif
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Reset in the middle of a stall.
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    ovr = 1'b1;
    #1;
    chk("held_inst", id_bus.if_to_id_inst, mem_word(32'h40));
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, id_bus.if_to_id_valid}, 32'd0);
    chk("async_rst_inst", id_bus.if_to_id_inst, NOP);
    chk("async_rst_allow_in", {31'b0, if_allow_in}, 32'd1);
    chk("async_rst_exc", {31'b0, id_bus.if_to_id_exc}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    ovr = 1'b0;
    drive(1'b1, 32'h44, 1'b1, 1'b0);
    push(32'h44, mem_word(32'h44), 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
